can_stream_bridge: RTL and testbench
====================================

# can_stream_bridge

Parametrised CAN test/monitor bridge between `can_top` and `uart_tx`. It generates periodic CAN transmit words in a selectable pattern and honours `tx_ready` back-pressure with drop accounting. It buffers received CAN data bytes whole-frame and serialises them as framed records (header, ID, data, byte count) onto a ready/valid byte stream that feeds `uart_tx`.

## Interface
- `TX_PERIOD`, 50000000: clock cycles between generated TX words; must be ≥ 2.
- `TX_MODE`, "INC": "INC" = seed+1, +2…; "LFSR" = 32-bit Galois LFSR; "CONST" = seed every time.
- `TX_SEED`, 32'h0: initial pattern register; for "LFSR" a zero seed is replaced by 32'h1.
- `FIFO_AW`, 5: RX FIFO depth = 2**FIFO_AW entries; must be ≥ 4.
- `FRAMED`, 1: 1 = emit header/ID/count around data; 0 = raw data bytes only.
- `clk` in 1: system clock.
- `rstn` in 1: reset; **one clock; reset is asynchronous and active-low**.
- `tx_enable` in 1: level; gates the period counter.
- `can_tx_valid` out 1; `can_tx_ready` in 1; `can_tx_data` out 32: to `can_top` tx port.
- `can_rx_valid` in 1; `can_rx_last` in 1; `can_rx_data` in 8; `can_rx_id` in 29; `can_rx_ide` in 1: from `can_top`. `can_rx_id` and `can_rx_ide` are stable for the whole frame.
- `out_valid` out 1; `out_ready` in 1; `out_data` out 8: byte stream to `uart_tx` (`tx_en` / `tx_rdy`).
- `tx_drop_cnt` out 16: saturating count of missed TX periods.
- `rx_drop_cnt` out 16: saturating count of dropped RX frames.

## Operation
- Reset: all outputs 0. Pattern register = seed. Period counter = 0. Serializer in IDLE. FIFO empty.
- TX period counter:
  - Counts 0..TX_PERIOD-1 while `tx_enable`=1. It holds while `tx_enable`=0, and pending valid is kept.
  - At the terminal count with `can_tx_valid`=0: advance the pattern, load `can_tx_data` with the new value, and assert valid.
  - At the terminal count with `can_tx_valid`=1: data is unchanged, the pattern does not advance, and `tx_drop_cnt` increments.
- TX handshake: `can_tx_valid` falls the cycle after a cycle with valid&ready. Data is stable while valid.
- LFSR step: if lsb=1, r = (r>>1) ^ 32'h80200003; else r = r>>1.
- RX admission is decided at the first byte of a frame (first `can_rx_valid` after reset or after a `can_rx_last`):
  - Admit the frame if free entries ≥ 8 (maximum CAN payload). Otherwise drop every byte through `can_rx_last` and increment `rx_drop_cnt` once.
  - An admitted frame always fits. Each byte is written as entry {first, last, ide, id, data}.
- Serializer states: IDLE, HDR, ID3, ID2, ID1, ID0, DATA, CNT.
  - FRAMED=1, entry with first=1: IDLE→HDR (0xA5).
  - HDR→ID3 if ide=1, else →ID1.
  - ID bytes are big-endian; 11-bit IDs are sent as {5'b0, id[10:8]}, id[7:0].
  - After the ID bytes, →DATA. DATA pops one entry per byte.
  - On a popped entry with last=1, →CNT, which emits the byte count (1..8). CNT→IDLE.
  - FRAMED=0: IDLE/DATA only; data bytes only.
- The byte counter is 4 bits and clears in HDR.

## Timing
- A state or byte advances only on `out_valid`&`out_ready`. `out_data` is stable while `out_valid`&!`out_ready`.
- Latency with empty FIFO and `out_ready`=1:
  - First RX byte at cycle n → write at n+1 → `out_valid` (header) at n+2.
  - FRAMED=0: data at n+2.
- A FIFO read and write in the same cycle are both performed. Full/empty flags use an FW+1-bit pointer compare.
- Pointers wrap modulo 2**FIFO_AW.
- Counters saturate at 16'hFFFF.
- Reset asserted mid-frame or mid-record: everything clears immediately. After reset the next `can_rx_valid` is treated as a frame start.

## Structure
- `can_bridge_pkg`: serializer state enum, `HDR_BYTE`=8'hA5, `LFSR_POLY`, `MAX_FRAME_BYTES`=8, entry struct.
- One sub-module: `sync_fifo` (parametrised width/depth, registered read data, count output used for free-space check).

## Test plan
- TX_PERIOD=10, INC, ready tied high, tx_enable=1 → valid pulses every 10 cycles with data 1, 2, 3…; drop count 0.
- ready held low for 35 cycles → data holds at 1, `tx_drop_cnt`=3; after release the next word is 2.
- LFSR with seed 0 → first word 32'h80200003 (from r=1), second word 32'hC0300002.
- FRAMED=1, 11-bit ID 0x123, 3 bytes 11,22,33 → out A5 01 23 11 22 33 03. 29-bit ID 0x12345678 → A5 12 34 56 78 … with count.
- FIFO_AW=4 with out_ready=0, two 8-byte frames then a third → third frame dropped, `rx_drop_cnt`=1; first two frames drained intact.
- Reset asserted mid-record during ID2 → outputs 0. A new frame afterwards emits a clean A5 header.

Source files
------------

// File: rtl/can_bridge_pkg.sv
// Shared types and constants for the CAN stream bridge.
// Serializer states, RX FIFO entry layout and the TX LFSR step.
package can_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_ID3,
        S_ID2,
        S_ID1,
        S_ID0,
        S_DATA,
        S_CNT
    } ser_state_e;

    localparam logic [7:0]  HDR_BYTE        = 8'hA5;
    localparam logic [31:0] LFSR_POLY       = 32'h80200003;
    localparam int          MAX_FRAME_BYTES = 8;

    typedef struct packed {
        logic        first;
        logic        last;
        logic        ide;
        logic [28:0] id;
        logic [7:0]  data;
    } rx_entry_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] r);
        return r[0] ? ((r >> 1) ^ LFSR_POLY) : (r >> 1);
    endfunction

endpackage

// File: rtl/can_stream_bridge_fifo.sv
// Synchronous FIFO with a registered head-of-queue output.
// rd_data_o always shows the oldest entry one cycle after it lands.
module sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 5
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          wr_en_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    output logic [W-1:0]  rd_data_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [W-1:0]  rd_data_q, rd_data_d;
    logic          full;
    logic          do_wr, do_rd;

    assign empty_o = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                     (wptr_q[AW] != rptr_q[AW]);
    assign count_o = wptr_q - rptr_q;
    assign do_wr   = wr_en_i && !full;
    assign do_rd   = rd_en_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q + {{AW{1'b0}}, do_wr};
        rptr_d = rptr_q + {{AW{1'b0}}, do_rd};
        // Bypass when the entry being written becomes the new head.
        if (do_wr && (wptr_q == rptr_d))
            rd_data_d = wr_data_i;
        else
            rd_data_d = mem_q[rptr_d[AW-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (do_wr)
            mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            rd_data_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/can_stream_bridge.sv
// CAN test/monitor bridge: periodic TX word generator plus
// whole-frame RX buffering serialised onto a ready/valid byte stream.
module can_stream_bridge
    import can_bridge_pkg::*;
#(
    parameter int          TX_PERIOD = 50000000,
    parameter string       TX_MODE   = "INC",
    parameter logic [31:0] TX_SEED   = 32'h0,
    parameter int          FIFO_AW   = 5,
    parameter bit          FRAMED    = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        tx_enable,
    output logic        can_tx_valid,
    input  logic        can_tx_ready,
    output logic [31:0] can_tx_data,
    input  logic        can_rx_valid,
    input  logic        can_rx_last,
    input  logic [7:0]  can_rx_data,
    input  logic [28:0] can_rx_id,
    input  logic        can_rx_ide,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [15:0] tx_drop_cnt,
    output logic [15:0] rx_drop_cnt
);

    localparam bit IS_LFSR  = (TX_MODE == "LFSR");
    localparam bit IS_CONST = (TX_MODE == "CONST");
    localparam logic [31:0] SEED0 =
        (IS_LFSR && TX_SEED == 32'h0) ? 32'h1 : TX_SEED;
    localparam int CW = (TX_PERIOD > 2) ? $clog2(TX_PERIOD) : 1;
    localparam logic [CW-1:0] TC = CW'(TX_PERIOD - 1);
    localparam int EW = $bits(rx_entry_t);
    localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(1 << FIFO_AW);
    localparam logic [FIFO_AW:0] MIN_FREE = (FIFO_AW+1)'(MAX_FRAME_BYTES);

    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [31:0]   pat_q, pat_d;
    logic [31:0]   txd_q, txd_d;
    logic          txv_q, txv_d;
    logic [15:0]   txdrop_q, txdrop_d;
    logic          tc;

    always_comb begin
        tc       = tx_enable && (pcnt_q == TC);
        pcnt_d   = pcnt_q;
        pat_d    = pat_q;
        txd_d    = txd_q;
        txv_d    = txv_q;
        txdrop_d = txdrop_q;
        if (tx_enable)
            pcnt_d = tc ? '0 : pcnt_q + CW'(1);
        if (txv_q && can_tx_ready)
            txv_d = 1'b0;
        if (tc) begin
            if (txv_q) begin
                if (txdrop_q != 16'hFFFF)
                    txdrop_d = txdrop_q + 16'd1;
            end else begin
                if (IS_LFSR)
                    pat_d = lfsr_step(pat_q);
                else if (!IS_CONST)
                    pat_d = pat_q + 32'd1;
                txd_d = pat_d;
                txv_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcnt_q   <= '0;
            pat_q    <= SEED0;
            txd_q    <= '0;
            txv_q    <= 1'b0;
            txdrop_q <= '0;
        end else begin
            pcnt_q   <= pcnt_d;
            pat_q    <= pat_d;
            txd_q    <= txd_d;
            txv_q    <= txv_d;
            txdrop_q <= txdrop_d;
        end
    end

    assign can_tx_valid = txv_q;
    assign can_tx_data  = txd_q;
    assign tx_drop_cnt  = txdrop_q;

    logic             in_frame_q, in_frame_d;
    logic             drop_q, drop_d;
    logic [15:0]      rxdrop_q, rxdrop_d;
    logic             sof, admit;
    logic             fifo_wr, fifo_rd, fifo_empty;
    logic [FIFO_AW:0] fifo_count;
    logic [EW-1:0]    fifo_rdata;
    rx_entry_t        wr_ent, head;

    assign head = rx_entry_t'(fifo_rdata);

    always_comb begin
        sof        = can_rx_valid && !in_frame_q;
        admit      = (DEPTH_L - fifo_count) >= MIN_FREE;
        in_frame_d = in_frame_q;
        drop_d     = drop_q;
        rxdrop_d   = rxdrop_q;
        fifo_wr    = 1'b0;
        wr_ent     = '{first: sof, last: can_rx_last, ide: can_rx_ide,
                       id: can_rx_id, data: can_rx_data};
        if (can_rx_valid) begin
            fifo_wr = sof ? admit : !drop_q;
            if (sof && !admit && rxdrop_q != 16'hFFFF)
                rxdrop_d = rxdrop_q + 16'd1;
            in_frame_d = !can_rx_last;
            drop_d     = can_rx_last ? 1'b0 : (sof ? !admit : drop_q);
        end
    end

    sync_fifo #(
        .W  (EW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .wr_en_i   (fifo_wr),
        .wr_data_i (wr_ent),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_rdata),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    ser_state_e st_q, st_d;
    logic [3:0] bcnt_q, bcnt_d;
    logic       ov;
    logic [7:0] od;

    always_comb begin
        st_d    = st_q;
        bcnt_d  = bcnt_q;
        ov      = 1'b0;
        od      = '0;
        fifo_rd = 1'b0;
        unique case (st_q)
            S_IDLE: begin
                if (!fifo_empty)
                    st_d = (FRAMED && head.first) ? S_HDR : S_DATA;
            end
            S_HDR: begin
                ov     = 1'b1;
                od     = HDR_BYTE;
                bcnt_d = '0;
                if (out_ready)
                    st_d = head.ide ? S_ID3 : S_ID1;
            end
            S_ID3: begin
                ov = 1'b1;
                od = {3'b0, head.id[28:24]};
                if (out_ready)
                    st_d = S_ID2;
            end
            S_ID2: begin
                ov = 1'b1;
                od = head.id[23:16];
                if (out_ready)
                    st_d = S_ID1;
            end
            S_ID1: begin
                ov = 1'b1;
                od = head.ide ? head.id[15:8] : {5'b0, head.id[10:8]};
                if (out_ready)
                    st_d = S_ID0;
            end
            S_ID0: begin
                ov = 1'b1;
                od = head.id[7:0];
                if (out_ready)
                    st_d = S_DATA;
            end
            S_DATA: begin
                ov = !fifo_empty;
                od = head.data;
                if (!fifo_empty && out_ready) begin
                    fifo_rd = 1'b1;
                    bcnt_d  = bcnt_q + 4'd1;
                    if (head.last)
                        st_d = FRAMED ? S_CNT : S_IDLE;
                end
            end
            S_CNT: begin
                ov = 1'b1;
                od = {4'b0, bcnt_q};
                if (out_ready)
                    st_d = S_IDLE;
            end
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_frame_q <= 1'b0;
            drop_q     <= 1'b0;
            rxdrop_q   <= '0;
            st_q       <= S_IDLE;
            bcnt_q     <= '0;
        end else begin
            in_frame_q <= in_frame_d;
            drop_q     <= drop_d;
            rxdrop_q   <= rxdrop_d;
            st_q       <= st_d;
            bcnt_q     <= bcnt_d;
        end
    end

    assign out_valid   = ov;
    assign out_data    = od;
    assign rx_drop_cnt = rxdrop_q;

endmodule

// File: tb/tb_can_stream_bridge.sv
// Scoreboard bench for can_stream_bridge: framed INC instance (a)
// and raw LFSR instance (b) sharing the RX stream and clock.
module tb_can_stream_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, tx_enable, a_txr, b_txr;
    logic        rx_valid, rx_last, rx_ide, out_ready;
    logic [7:0]  rx_data;
    logic [28:0] rx_id;
    logic        a_tv, b_tv, a_ov, b_ov;
    logic [31:0] a_td, b_td;
    logic [7:0]  a_od, b_od;
    logic [15:0] a_tdrop, b_tdrop, a_rdrop, b_rdrop;

    int total = 0;
    int bad   = 0;
    logic [7:0]  qa[$], qb[$];
    logic [31:0] qta[$], qtb[$];
    bit chk_ta = 0, chk_tb = 0, gap_on = 0;
    int cyc = 0, last_a = -1;

    can_stream_bridge #(
        .TX_PERIOD(10), .TX_MODE("INC"), .TX_SEED(32'h0),
        .FIFO_AW(4), .FRAMED(1'b1)
    ) ua (
        .clk(clk), .rstn(rstn), .tx_enable(tx_enable),
        .can_tx_valid(a_tv), .can_tx_ready(a_txr), .can_tx_data(a_td),
        .can_rx_valid(rx_valid), .can_rx_last(rx_last),
        .can_rx_data(rx_data), .can_rx_id(rx_id), .can_rx_ide(rx_ide),
        .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od),
        .tx_drop_cnt(a_tdrop), .rx_drop_cnt(a_rdrop)
    );

    can_stream_bridge #(
        .TX_PERIOD(10), .TX_MODE("LFSR"), .TX_SEED(32'h0),
        .FIFO_AW(4), .FRAMED(1'b0)
    ) ub (
        .clk(clk), .rstn(rstn), .tx_enable(tx_enable),
        .can_tx_valid(b_tv), .can_tx_ready(b_txr), .can_tx_data(b_td),
        .can_rx_valid(rx_valid), .can_rx_last(rx_last),
        .can_rx_data(rx_data), .can_rx_id(rx_id), .can_rx_ide(rx_ide),
        .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od),
        .tx_drop_cnt(b_tdrop), .rx_drop_cnt(b_rdrop)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic extra(input string nm, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %h want nothing", nm, act);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rstn === 1'b1) begin
            if (a_ov && out_ready) begin
                if (qa.size() == 0) extra("a_out", a_od);
                else chk("a_out", a_od, qa.pop_front());
            end
            if (b_ov && out_ready) begin
                if (qb.size() == 0) extra("b_out", b_od);
                else chk("b_out", b_od, qb.pop_front());
            end
            if (chk_ta && a_tv && a_txr) begin
                if (gap_on && last_a >= 0)
                    chk("a_tx_gap", cyc - last_a, 10);
                last_a = cyc;
                if (qta.size() == 0) extra("a_tx", a_td);
                else chk("a_tx", a_td, qta.pop_front());
            end
            if (chk_tb && b_tv && b_txr) begin
                if (qtb.size() == 0) extra("b_tx", b_td);
                else chk("b_tx", b_td, qtb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rstn = 1'b0;
        qa.delete(); qb.delete(); qta.delete(); qtb.delete();
        last_a = -1;
        repeat (2) tick();
        rstn = 1'b1;
    endtask

    task automatic drain(input string nm, input int lim);
        int n = 0;
        while ((qa.size() + qb.size() + qta.size() + qtb.size()) != 0
               && n < lim) begin
            tick();
            n++;
        end
        chk(nm, qa.size() + qb.size() + qta.size() + qtb.size(), 0);
    endtask

    task automatic push_rec(input logic [28:0] id, input logic ide,
                            input int n, input logic [7:0] b0,
                            input logic [7:0] st);
        qa.push_back(8'hA5);
        if (ide) begin
            qa.push_back({3'b0, id[28:24]});
            qa.push_back(id[23:16]);
            qa.push_back(id[15:8]);
        end else begin
            qa.push_back({5'b0, id[10:8]});
        end
        qa.push_back(id[7:0]);
        for (int i = 0; i < n; i++) begin
            qa.push_back(b0 + 8'(i) * st);
            qb.push_back(b0 + 8'(i) * st);
        end
        qa.push_back(8'(n));
    endtask

    task automatic send(input logic [28:0] id, input logic ide, input int n,
                        input logic [7:0] b0, input logic [7:0] st,
                        input bit last_en, input bit lat);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_id    = id;
            rx_ide   = ide;
            rx_data  = b0 + 8'(i) * st;
            rx_last  = last_en && (i == n - 1);
            if (lat && i == 1) begin
                @(negedge clk);
                chk("a_lat_n1", a_ov, 0);
                chk("b_lat_n1", b_ov, 0);
            end
            if (lat && i == 2) begin
                @(negedge clk);
                chk("a_lat_n2", a_ov, 1);
                chk("b_lat_n2", b_ov, 1);
            end
            tick();
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    initial begin
        int n;
        rstn = 1'b0; tx_enable = 1'b0; a_txr = 1'b0; b_txr = 1'b0;
        rx_valid = 1'b0; rx_last = 1'b0; rx_ide = 1'b0; out_ready = 1'b0;
        rx_data = '0; rx_id = '0;
        repeat (2) tick();
        chk("rst_a_tv", a_tv, 0);
        chk("rst_a_td", a_td, 0);
        chk("rst_b_td", b_td, 0);
        chk("rst_a_ov", a_ov, 0);
        chk("rst_a_od", a_od, 0);
        chk("rst_a_tdrop", a_tdrop, 0);
        chk("rst_a_rdrop", a_rdrop, 0);
        rstn = 1'b1;

        // TX free-running: INC 1..4 and LFSR from seed 0
        chk_ta = 1; chk_tb = 1; gap_on = 1;
        qta.push_back(32'd1); qta.push_back(32'd2);
        qta.push_back(32'd3); qta.push_back(32'd4);
        qtb.push_back(32'h80200003); qtb.push_back(32'hC0300002);
        qtb.push_back(32'h60180001); qtb.push_back(32'hB02C0003);
        a_txr = 1'b1; b_txr = 1'b1;
        tick();
        tx_enable = 1'b1;
        drain("tx_run_drain", 100);
        tx_enable = 1'b0;
        chk("a_tdrop_zero", a_tdrop, 0);
        chk("b_tdrop_zero", b_tdrop, 0);
        gap_on = 0; chk_tb = 0;

        // TX back-pressure for 35 cycles
        do_reset();
        a_txr = 1'b0;
        qta.push_back(32'd1); qta.push_back(32'd2);
        tx_enable = 1'b1;
        n = 0;
        while (a_tv !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("a_tv_rise", a_tv, 1);
        repeat (35) @(posedge clk);
        #1;
        chk("hold_valid", a_tv, 1);
        chk("hold_data", a_td, 1);
        chk("hold_drop3", a_tdrop, 3);
        a_txr = 1'b1;
        drain("tx_bp_drain", 40);
        tx_enable = 1'b0;
        chk("drop3_after", a_tdrop, 3);
        chk_ta = 0;

        // Framed records, 11-bit and 29-bit IDs
        do_reset();
        out_ready = 1'b1;
        push_rec(29'h123, 1'b0, 3, 8'h11, 8'h11);
        send(29'h123, 1'b0, 3, 8'h11, 8'h11, 1'b1, 1'b1);
        push_rec(29'h12345678, 1'b1, 2, 8'h01, 8'h01);
        send(29'h12345678, 1'b1, 2, 8'h01, 8'h01, 1'b1, 1'b0);
        drain("rx_rec_drain", 100);
        chk("a_rdrop_zero", a_rdrop, 0);

        // FIFO full: third 8-byte frame must be dropped
        out_ready = 1'b0;
        send(29'h7FF, 1'b0, 8, 8'h10, 8'h01, 1'b1, 1'b0);
        tick();
        send(29'h055, 1'b0, 8, 8'h20, 8'h01, 1'b1, 1'b0);
        tick();
        send(29'h0AA, 1'b0, 8, 8'h30, 8'h01, 1'b1, 1'b0);
        @(negedge clk);
        chk("a_rdrop_one", a_rdrop, 1);
        chk("b_rdrop_one", b_rdrop, 1);
        chk("a_stall_valid", a_ov, 1);
        chk("a_stall_hdr", a_od, 8'hA5);
        chk("b_stall_data", b_od, 8'h10);
        push_rec(29'h7FF, 1'b0, 8, 8'h10, 8'h01);
        push_rec(29'h055, 1'b0, 8, 8'h20, 8'h01);
        tick();
        out_ready = 1'b1;
        drain("rx_full_drain", 200);

        // Reset mid-record at ID2, with an unfinished RX frame
        out_ready = 1'b0;
        send(29'h1ABCDEF1, 1'b1, 5, 8'h40, 8'h01, 1'b0, 1'b0);
        qa.push_back(8'hA5); qa.push_back(8'h1A);
        qb.push_back(8'h40); qb.push_back(8'h41);
        out_ready = 1'b1;
        repeat (2) tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("at_id2_valid", a_ov, 1);
        chk("at_id2_byte", a_od, 8'hBC);
        chk("b_third_byte", b_od, 8'h42);
        tick();
        rstn = 1'b0;
        qa.delete(); qb.delete();
        #1;
        chk("mid_rst_a_ov", a_ov, 0);
        chk("mid_rst_a_od", a_od, 0);
        chk("mid_rst_b_ov", b_ov, 0);
        chk("mid_rst_b_od", b_od, 0);
        chk("mid_rst_rdrop", a_rdrop, 0);
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        out_ready = 1'b1;
        push_rec(29'h321, 1'b0, 1, 8'h5A, 8'h00);
        send(29'h321, 1'b0, 1, 8'h5A, 8'h00, 1'b1, 1'b0);
        drain("post_rst_drain", 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
